// File: rtl/alu_wb_sequencer.sv
// Wishbone-controlled operand/opcode holder and result capture sequencer
// for the 4-lane ALU. A START write runs a fixed-latency settle window,
// then the result and per-lane flags are latched and DONE is raised.
module alu_wb_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned LATENCY   = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [63:0] alu_a_o,
  output logic [63:0] alu_b_o,
  output logic [3:0]  alu_op_o,
  input  logic [63:0] alu_result_i,
  input  logic [3:0]  alu_exception_i,
  input  logic [3:0]  alu_overflow_i,
  input  logic [3:0]  alu_underflow_i,
  output logic        irq_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [5:0] W_CTRL   = 6'h00;
  localparam logic [5:0] W_STATUS = 6'h01;
  localparam logic [5:0] W_A_LO   = 6'h02;
  localparam logic [5:0] W_A_HI   = 6'h03;
  localparam logic [5:0] W_B_LO   = 6'h04;
  localparam logic [5:0] W_B_HI   = 6'h05;
  localparam logic [5:0] W_RES_LO = 6'h06;
  localparam logic [5:0] W_RES_HI = 6'h07;
  localparam logic [5:0] W_FLAGS  = 6'h08;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] a_lo_q, a_lo_d, a_hi_q, a_hi_d;
  logic [31:0] b_lo_q, b_lo_d, b_hi_q, b_hi_d;
  logic [3:0]  op_q, op_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [63:0] res_q, res_d;
  logic [31:0] flags_q, flags_d;
  logic        irq_q, irq_d;

  logic        in_win, hit, wr, rd, busy, start;
  logic [5:0]  word;
  logic [31:0] rd_mux;
  logic        unused_adr;

  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  // Byte-lane merge of write data into an existing register value.
  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] new_v,
                                        input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

  // Next-state: bus decode, register writes, FSM sequencing and capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_lo_d   = a_lo_q;
    a_hi_d   = a_hi_q;
    b_lo_d   = b_lo_q;
    b_hi_d   = b_hi_q;
    op_d     = op_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;
    res_d    = res_q;
    flags_d  = flags_q;
    start    = 1'b0;
    rd_mux   = '0;

    in_win = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    hit    = wbs_cyc_i & wbs_stb_i & in_win;
    // Suppress an ack directly after an ack so each transfer is two cycles.
    ack_d  = hit & ~ack_q;
    wr     = ack_d & wbs_we_i;
    rd     = ack_d & ~wbs_we_i;
    word   = wbs_adr_i[7:2];
    busy   = (state_q == RUN);

    if (wr) begin
      case (word)
        W_CTRL: begin
          if (wbs_sel_i[0] && !busy) begin
            op_d  = wbs_dat_i[7:4];
            start = wbs_dat_i[0];
          end
          if (wbs_sel_i[1]) irq_en_d = wbs_dat_i[8];
        end
        W_STATUS: if (wbs_sel_i[0] && wbs_dat_i[1]) done_d = 1'b0;
        W_A_LO:   if (!busy) a_lo_d = merge(a_lo_q, wbs_dat_i, wbs_sel_i);
        W_A_HI:   if (!busy) a_hi_d = merge(a_hi_q, wbs_dat_i, wbs_sel_i);
        W_B_LO:   if (!busy) b_lo_d = merge(b_lo_q, wbs_dat_i, wbs_sel_i);
        W_B_HI:   if (!busy) b_hi_d = merge(b_hi_q, wbs_dat_i, wbs_sel_i);
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CNT_LOAD;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (cnt_q == 4'd0) begin
          // Capture is applied after the W1C above so a set on the same edge wins.
          state_d = IDLE;
          res_d   = alu_result_i;
          flags_d = {12'b0, alu_underflow_i, 4'b0, alu_overflow_i, 4'b0, alu_exception_i};
          err_d   = |{alu_underflow_i, alu_overflow_i, alu_exception_i};
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (word)
      W_CTRL:   rd_mux = {23'b0, irq_en_q, op_q, 4'b0};
      W_STATUS: rd_mux = {29'b0, err_q, done_q, busy};
      W_A_LO:   rd_mux = a_lo_q;
      W_A_HI:   rd_mux = a_hi_q;
      W_B_LO:   rd_mux = b_lo_q;
      W_B_HI:   rd_mux = b_hi_q;
      W_RES_LO: rd_mux = res_q[31:0];
      W_RES_HI: rd_mux = res_q[63:32];
      W_FLAGS:  rd_mux = flags_q;
      default:  rd_mux = '0;
    endcase

    dat_d = rd ? rd_mux : '0;
    irq_d = done_q & irq_en_q;
  end

  // State registers with synchronous reset; a reset mid-run aborts the capture.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      a_lo_q   <= '0;
      a_hi_q   <= '0;
      b_lo_q   <= '0;
      b_hi_q   <= '0;
      op_q     <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      res_q    <= '0;
      flags_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      a_lo_q   <= a_lo_d;
      a_hi_q   <= a_hi_d;
      b_lo_q   <= b_lo_d;
      b_hi_q   <= b_hi_d;
      op_q     <= op_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      irq_q    <= irq_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign alu_a_o   = {a_hi_q, a_lo_q};
  assign alu_b_o   = {b_hi_q, b_lo_q};
  assign alu_op_o  = op_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_alu_wb_sequencer.sv
// Directed bench for alu_wb_sequencer. The ALU model only presents the
// expected result/flags in the single cycle before the intended capture edge,
// so an early, late or repeated capture latches the "bad" pattern instead.
module tb_alu_wb_sequencer;

  localparam int unsigned LAT  = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [63:0] alu_a_o, alu_b_o;
  logic [3:0]  alu_op_o;
  logic [63:0] alu_result_i;
  logic [3:0]  alu_exception_i, alu_overflow_i, alu_underflow_i;
  logic        irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned cnt = 0;
  int unsigned start_cnt = 0;
  logic        armed = 1'b0;
  logic        win;
  logic [63:0] good_res = 64'hDEADBEEF_01234567;
  logic [3:0]  good_exc = 4'h0, good_ov = 4'h0, good_un = 4'h0;

  always #5 clk = ~clk;

  always @(posedge clk) cnt <= cnt + 1;

  assign win             = armed && (cnt == start_cnt + LAT - 1);
  assign alu_result_i    = win ? good_res : 64'hBAD0_0000_BAD0_0000;
  assign alu_exception_i = win ? good_exc : 4'hF;
  assign alu_overflow_i  = win ? good_ov  : 4'hF;
  assign alu_underflow_i = win ? good_un  : 4'hF;

  alu_wb_sequencer #(.BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (wb_rst_i),
    .wbs_cyc_i       (wbs_cyc_i),
    .wbs_stb_i       (wbs_stb_i),
    .wbs_we_i        (wbs_we_i),
    .wbs_sel_i       (wbs_sel_i),
    .wbs_adr_i       (wbs_adr_i),
    .wbs_dat_i       (wbs_dat_i),
    .wbs_ack_o       (wbs_ack_o),
    .wbs_dat_o       (wbs_dat_o),
    .alu_a_o         (alu_a_o),
    .alu_b_o         (alu_b_o),
    .alu_op_o        (alu_op_o),
    .alu_result_i    (alu_result_i),
    .alu_exception_i (alu_exception_i),
    .alu_overflow_i  (alu_overflow_i),
    .alu_underflow_i (alu_underflow_i),
    .irq_o           (irq_o)
  );

  // One bus transfer starting now; returns ack latency (0 = none within 8
  // cycles), read data, and the ack level one cycle after the ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                         input logic [3:0] sel, output logic [31:0] rdat,
                         output int unsigned cyc_n, output logic ack_after);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
    cyc_n = 0;
    rdat  = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        cyc_n = i;
        rdat  = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk); #1;
    ack_after = wbs_ack_o;
  endtask

  task automatic wb_wr(input logic [7:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r; int unsigned c; logic a;
    wb_xfer(1'b1, BASE + {24'h0, off}, d, sel, r, c, a);
    n_checks++;
    if (c == 0) begin
      n_fail++;
      $display("FAIL wr_timeout off=%h: no ack (required ack within 8 cycles)", off);
    end
  endtask

  task automatic wb_rd(input logic [7:0] off, output logic [31:0] d);
    int unsigned c; logic a;
    wb_xfer(1'b0, BASE + {24'h0, off}, 32'h0, 4'h0, d, c, a);
    n_checks++;
    if (c == 0) begin
      n_fail++;
      $display("FAIL rd_timeout off=%h: no ack (required ack within 8 cycles)", off);
    end
  endtask

  // Arm the ALU model relative to a START acked one cycle before now.
  task automatic arm_model();
    start_cnt = cnt - 1;
    armed     = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] r; int unsigned c; logic a;
    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;
    repeat (3) @(posedge clk);
    #1 wb_rst_i = 1'b0;
    n_checks++;
    if (irq_o !== 1'b0 || wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outs irq=%b ack=%b dat=%h required 0/0/0", irq_o, wbs_ack_o, wbs_dat_o);
    end
    n_checks++;
    if (alu_a_o !== 64'h0 || alu_b_o !== 64'h0 || alu_op_o !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_alu a=%h b=%h op=%h required 0", alu_a_o, alu_b_o, alu_op_o);
    end
    for (int unsigned off = 0; off <= 8'h24; off += 4) begin
      wb_xfer(1'b0, BASE + off, 32'h0, 4'h0, r, c, a);
      n_checks++;
      if (r !== 32'h0 || c !== 1 || a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_read off=%h data=%h lat=%0d ack_after=%b required 0/1/0", off, r, c, a);
      end
    end
    // Unmapped in-window offset: acked, write has no effect.
    wb_xfer(1'b1, BASE + 32'h24, 32'hFFFF_FFFF, 4'hF, r, c, a);
    wb_xfer(1'b0, BASE + 32'h24, 32'h0, 4'h0, r, c, a);
    n_checks++;
    if (r !== 32'h0 || c !== 1) begin
      n_fail++;
      $display("FAIL unmapped data=%h lat=%0d required 0/1", r, c);
    end
    // Outside the window: never acked.
    wb_xfer(1'b1, BASE + 32'h108, 32'h1, 4'hF, r, c, a);
    n_checks++;
    if (c !== 0) begin
      n_fail++;
      $display("FAIL out_of_window ack_latency=%0d required no ack", c);
    end
  endtask

  task automatic test_run();
    logic [31:0] r;
    wb_wr(8'h08, 32'h4000_0000, 4'hF);
    wb_wr(8'h0C, 32'h3F80_0000, 4'hF);
    wb_wr(8'h10, 32'h4080_0000, 4'hF);
    wb_wr(8'h14, 32'h4040_0000, 4'hF);
    n_checks++;
    if (alu_a_o !== 64'h3F800000_40000000 || alu_b_o !== 64'h40400000_40800000) begin
      n_fail++;
      $display("FAIL operands a=%h b=%h required 3f80000040000000/4040000040800000", alu_a_o, alu_b_o);
    end
    good_exc = 4'h0; good_ov = 4'h0; good_un = 4'h0;
    wb_wr(8'h00, 32'h011, 4'hF);
    arm_model();
    n_checks++;
    if (alu_op_o !== 4'h1) begin
      n_fail++;
      $display("FAIL op_drive op=%h required 1", alu_op_o);
    end
    wb_rd(8'h04, r);
    n_checks++;
    if (r !== 32'h1) begin
      n_fail++;
      $display("FAIL status_busy status=%h required 00000001", r);
    end
    repeat (6) @(posedge clk);
    #1;
    wb_rd(8'h04, r);
    n_checks++;
    if (r !== 32'h2) begin
      n_fail++;
      $display("FAIL status_done status=%h required 00000002", r);
    end
    wb_rd(8'h18, r);
    n_checks++;
    if (r !== 32'h0123_4567) begin
      n_fail++;
      $display("FAIL res_lo got=%h required 01234567", r);
    end
    wb_rd(8'h1C, r);
    n_checks++;
    if (r !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL res_hi got=%h required deadbeef", r);
    end
    wb_rd(8'h00, r);
    n_checks++;
    if (r !== 32'h10) begin
      n_fail++;
      $display("FAIL ctrl_read got=%h required 00000010", r);
    end
  endtask

  task automatic test_flags();
    logic [31:0] r;
    good_exc = 4'b1000; good_ov = 4'b0101; good_un = 4'b0000;
    wb_wr(8'h00, 32'h011, 4'hF);
    arm_model();
    repeat (6) @(posedge clk);
    #1;
    wb_rd(8'h20, r);
    n_checks++;
    if (r !== 32'h0000_0508) begin
      n_fail++;
      $display("FAIL flags got=%h required 00000508", r);
    end
    wb_rd(8'h04, r);
    n_checks++;
    if (r !== 32'h6) begin
      n_fail++;
      $display("FAIL status_err status=%h required 00000006", r);
    end
    good_exc = 4'h0; good_ov = 4'h0;
  endtask

  task automatic test_irq();
    logic [31:0] r;
    wb_wr(8'h00, 32'h111, 4'hF);
    arm_model();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_on_capture_edge irq=%b required 0", irq_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_rise irq=%b required 1", irq_o);
    end
    wb_wr(8'h04, 32'h2, 4'hF);
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_clear irq=%b required 0", irq_o);
    end
    // W1C landing on the capture edge: DONE must survive.
    wb_wr(8'h00, 32'h111, 4'hF);
    arm_model();
    repeat (2) @(posedge clk);
    #1;
    wb_wr(8'h04, 32'h2, 4'hF);
    wb_rd(8'h04, r);
    n_checks++;
    if (r !== 32'h2) begin
      n_fail++;
      $display("FAIL w1c_vs_set status=%h required 00000002", r);
    end
    n_checks++;
    if (irq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_after_race irq=%b required 1", irq_o);
    end
    wb_wr(8'h04, 32'h2, 4'hF);
    wb_wr(8'h00, 32'h010, 4'hF);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    wb_wr(8'h00, 32'h011, 4'hF);
    arm_model();
    wb_wr(8'h08, 32'hFFFF_FFFF, 4'hF);
    wb_wr(8'h00, 32'h0F1, 4'hF);
    n_checks++;
    if (alu_a_o !== 64'h3F800000_40000000 || alu_op_o !== 4'h1) begin
      n_fail++;
      $display("FAIL busy_hold a=%h op=%h required 3f80000040000000/1", alu_a_o, alu_op_o);
    end
    repeat (8) @(posedge clk);
    #1;
    wb_rd(8'h18, r);
    n_checks++;
    if (r !== 32'h0123_4567) begin
      n_fail++;
      $display("FAIL single_capture res_lo=%h required 01234567", r);
    end
    wb_rd(8'h04, r);
    n_checks++;
    if (r !== 32'h2) begin
      n_fail++;
      $display("FAIL busy_once status=%h required 00000002", r);
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] r, s, lo, hi, fl;
    wb_wr(8'h00, 32'h011, 4'hF);
    arm_model();
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    wb_rd(8'h04, s);
    wb_rd(8'h18, lo);
    wb_rd(8'h1C, hi);
    wb_rd(8'h20, fl);
    n_checks++;
    if (s !== 32'h0 || lo !== 32'h0 || hi !== 32'h0 || fl !== 32'h0) begin
      n_fail++;
      $display("FAIL abort_state status=%h res=%h_%h flags=%h required all 0", s, hi, lo, fl);
    end
    repeat (6) @(posedge clk);
    #1;
    wb_rd(8'h04, s);
    wb_rd(8'h18, lo);
    n_checks++;
    if (s !== 32'h0 || lo !== 32'h0) begin
      n_fail++;
      $display("FAIL no_capture status=%h res_lo=%h required 0/0", s, lo);
    end
    wb_wr(8'h10, 32'hAABB_CCDD, 4'b0010);
    wb_rd(8'h10, r);
    n_checks++;
    if (r !== 32'h0000_CC00 || alu_b_o !== 64'h0000_0000_0000_CC00) begin
      n_fail++;
      $display("FAIL byte_sel b_lo=%h alu_b=%h required 0000cc00", r, alu_b_o);
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_flags();
    test_irq();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
